// File: rtl/icache_pkg.sv
// Shared constants and width helpers for the N-way instruction cache.
package icache_pkg;

  // Miss-handling FSM encoding
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MISS_REQ  = 2'd1;
  localparam logic [1:0] MISS_WAIT = 2'd2;

  // 8-byte lines
  localparam int unsigned LINE_OFF_W = 3;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
    return addr_w - LINE_OFF_W - $clog2(sets);
  endfunction

  // Way index width; a direct-mapped cache still carries a 1-bit index
  function automatic int unsigned way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tree-PLRU bits per set; a direct-mapped cache keeps one dummy bit
  function automatic int unsigned plru_w(input int unsigned ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU for one set: next state after touching a way, plus the
// current victim. Each tree bit points toward the less recently used side.
module icache_plru import icache_pkg::*; #(
  parameter int unsigned WAYS = 2
) (
  input  logic [plru_w(WAYS)-1:0] i_bits,
  input  logic [way_w(WAYS)-1:0]  i_way,
  output logic [plru_w(WAYS)-1:0] o_bits,
  output logic [way_w(WAYS)-1:0]  o_victim
);

  generate
    if (WAYS == 4) begin : g_four
      // bit0 = root, bit1 = pair {0,1}, bit2 = pair {2,3}
      always_comb begin
        o_bits    = i_bits;
        o_bits[0] = ~i_way[1];
        if (!i_way[1]) o_bits[1] = ~i_way[0];
        else           o_bits[2] = ~i_way[0];
        o_victim  = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};
      end
    end else if (WAYS == 2) begin : g_two
      // Single bit naming the way not touched last
      always_comb begin
        o_bits   = ~i_way;
        o_victim = i_bits;
      end
    end else begin : g_one
      logic w_unused_in;
      assign w_unused_in = ^{i_bits, i_way};
      // Direct-mapped: no replacement state
      always_comb begin
        o_bits   = '0;
        o_victim = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with one outstanding line fill,
// hit-under-miss lookups and coherency invalidation.
module icache_nway import icache_pkg::*; #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc2Icache_req,
  input  logic [ADDR_W-1:0] proc2Icache_addr,
  output logic [63:0]       Icache2proc_data,
  output logic              Icache2proc_valid,
  output logic              Icache2mem_req,
  output logic [ADDR_W-1:0] Icache2mem_addr,
  input  logic              mem2Icache_ack,
  input  logic              mem2Icache_data_valid,
  input  logic [63:0]       mem2Icache_data,
  input  logic              inval_en,
  input  logic [ADDR_W-1:0] inval_addr
);

  localparam int unsigned IdxW  = idx_w(SETS);
  localparam int unsigned TagW  = tag_w(ADDR_W, SETS);
  localparam int unsigned WayW  = way_w(WAYS);
  localparam int unsigned PlruW = plru_w(WAYS);
  localparam int unsigned LineW = ADDR_W - LINE_OFF_W;

  logic [TagW-1:0]  r_tag  [SETS][WAYS];
  logic [63:0]      r_data [SETS][WAYS];
  logic [WAYS-1:0]  r_valid[SETS];
  logic [PlruW-1:0] r_plru [SETS];
  logic [1:0]       r_state;
  logic             r_poison;
  logic [LineW-1:0] r_line;

  logic [LineW-1:0] w_req_line, w_inv_line;
  logic [IdxW-1:0]  w_req_idx, w_inv_idx, w_fill_idx;
  logic [TagW-1:0]  w_req_tag, w_inv_tag, w_fill_tag;
  logic             w_hit, w_fill_en, w_fill_valid, w_inv_pend, w_found;
  logic [WayW-1:0]  w_hit_way, w_fill_way, w_plru_victim, w_unused_victim;
  logic [WAYS-1:0]  w_inv_hit;
  logic [PlruW-1:0] w_plru_hit, w_plru_fill_in, w_plru_fill;
  logic [1:0]       w_state_d;
  logic             w_poison_d;
  logic [LineW-1:0] w_line_d;
  logic             w_unused_off;

  assign w_unused_off = ^{proc2Icache_addr[LINE_OFF_W-1:0], inval_addr[LINE_OFF_W-1:0]};
  assign w_req_line   = proc2Icache_addr[ADDR_W-1:LINE_OFF_W];
  assign w_inv_line   = inval_addr[ADDR_W-1:LINE_OFF_W];
  assign w_req_idx    = w_req_line[IdxW-1:0];
  assign w_req_tag    = w_req_line[LineW-1:IdxW];
  assign w_inv_idx    = w_inv_line[IdxW-1:0];
  assign w_inv_tag    = w_inv_line[LineW-1:IdxW];
  assign w_fill_idx   = r_line[IdxW-1:0];
  assign w_fill_tag   = r_line[LineW-1:IdxW];

  // Processor lookup, served in every FSM state
  always_comb begin
    w_hit            = 1'b0;
    w_hit_way        = '0;
    Icache2proc_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_req_idx][w] && r_tag[w_req_idx][w] == w_req_tag) begin
        w_hit            = 1'b1;
        w_hit_way        = WayW'(w);
        Icache2proc_data = r_data[w_req_idx][w];
      end
    end
  end

  assign Icache2proc_valid = proc2Icache_req && w_hit;

  // Ways holding the line named by the invalidate port
  always_comb begin
    w_inv_hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_inv_hit[w] = inval_en && r_valid[w_inv_idx][w] && r_tag[w_inv_idx][w] == w_inv_tag;
    end
  end

  // Fill victim: lowest invalid way, otherwise the PLRU choice
  always_comb begin
    w_found    = 1'b0;
    w_fill_way = w_plru_victim;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !r_valid[w_fill_idx][w]) begin
        w_found    = 1'b1;
        w_fill_way = WayW'(w);
      end
    end
  end

  // A hit and a fill in the same set compose: hit touch first, then the fill
  assign w_plru_fill_in = (Icache2proc_valid && w_req_idx == w_fill_idx) ? w_plru_hit
                                                                         : r_plru[w_fill_idx];

  icache_plru #(.WAYS(WAYS)) u_plru_hit (
    .i_bits  (r_plru[w_req_idx]),
    .i_way   (w_hit_way),
    .o_bits  (w_plru_hit),
    .o_victim(w_unused_victim)
  );

  icache_plru #(.WAYS(WAYS)) u_plru_fill (
    .i_bits  (w_plru_fill_in),
    .i_way   (w_fill_way),
    .o_bits  (w_plru_fill),
    .o_victim(w_plru_victim)
  );

  // Miss FSM next state, poison tracking and fill strobe
  always_comb begin
    w_state_d  = r_state;
    w_poison_d = r_poison;
    w_line_d   = r_line;
    w_fill_en  = 1'b0;
    w_inv_pend = inval_en && w_inv_line == r_line;
    unique case (r_state)
      IDLE: begin
        if (proc2Icache_req && !w_hit && !(inval_en && w_inv_line == w_req_line)) begin
          w_line_d  = w_req_line;
          w_state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (w_inv_pend) w_poison_d = 1'b1;
        if (mem2Icache_ack) w_state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (w_inv_pend) w_poison_d = 1'b1;
        if (mem2Icache_data_valid) begin
          w_fill_en  = 1'b1;
          w_state_d  = IDLE;
          w_poison_d = 1'b0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Same-edge invalidate of the fill line also keeps it invalid
  assign w_fill_valid    = !(r_poison || w_inv_pend);
  assign Icache2mem_req  = (r_state == MISS_REQ);
  assign Icache2mem_addr = Icache2mem_req ? {r_line, {LINE_OFF_W{1'b0}}} : '0;

  // FSM, captured line and poison flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_poison <= 1'b0;
      r_line   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_poison <= w_poison_d;
      r_line   <= w_line_d;
    end
  end

  // Valid bits: fill sets, invalidate clears (never the way being refilled)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else begin
      if (w_fill_en) r_valid[w_fill_idx][w_fill_way] <= w_fill_valid;
      for (int w = 0; w < WAYS; w++) begin
        if (w_inv_hit[w] &&
            !(w_fill_en && w_fill_idx == w_inv_idx && w_fill_way == WayW'(w))) begin
          r_valid[w_inv_idx][w] <= 1'b0;
        end
      end
    end
  end

  // PLRU state per set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else begin
      if (Icache2proc_valid) r_plru[w_req_idx] <= w_plru_hit;
      if (w_fill_en)         r_plru[w_fill_idx] <= w_plru_fill;
    end
  end

  // Tag and data arrays carry no reset
  always_ff @(posedge clock) begin
    if (w_fill_en) begin
      r_tag[w_fill_idx][w_fill_way]  <= w_fill_tag;
      r_data[w_fill_idx][w_fill_way] <= mem2Icache_data;
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway (2 ways, 64 sets, 64-bit addresses).
// The reference keeps per-set line lists with true LRU order.
module tb_icache_nway;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, ack, dval, inv;
  logic [63:0] addr, mdata, inva;
  logic [63:0] pdata;
  logic        pvalid, mreq;
  logic [63:0] maddr;

  icache_nway #(.WAYS(2), .SETS(64), .ADDR_W(64)) dut (
    .clock                (clock),
    .reset                (reset),
    .proc2Icache_req      (req),
    .proc2Icache_addr     (addr),
    .Icache2proc_data     (pdata),
    .Icache2proc_valid    (pvalid),
    .Icache2mem_req       (mreq),
    .Icache2mem_addr      (maddr),
    .mem2Icache_ack       (ack),
    .mem2Icache_data_valid(dval),
    .mem2Icache_data      (mdata),
    .inval_en             (inv),
    .inval_addr           (inva)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        v;
    logic [63:0] d;
    logic        mr;
    logic [63:0] ma;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference state
  bit          mv [64][2];
  logic [63:0] mt [64][2];
  logic [63:0] md [64][2];
  int          mru[64];
  int          phase;   // 0 idle, 1 requesting, 2 waiting for data
  bit          mpois;
  logic [63:0] mline;

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 0;
      mv[s][1] = 0;
      mru[s]   = 1;
    end
    phase = 0;
    mpois = 0;
    mline = 0;
  endfunction

  function automatic void lookup(input logic [63:0] a, output bit hit, output int way,
                                 output int idx);
    logic [63:0] line;
    line = a >> 3;
    idx  = int'(line % 64);
    hit  = 0;
    way  = 0;
    for (int w = 0; w < 2; w++) begin
      if (!hit && mv[idx][w] && mt[idx][w] == line / 64) begin
        hit = 1;
        way = w;
      end
    end
  endfunction

  function automatic void model_advance(input logic rq, input logic [63:0] a, input logic ak,
                                        input logic dv, input logic [63:0] d, input logic ie,
                                        input logic [63:0] ia);
    bit hit, inv_pend;
    bit inv_m[2];
    int hw, ridx, iidx, fidx, fw;
    lookup(a, hit, hw, ridx);
    iidx = int'((ia >> 3) % 64);
    for (int w = 0; w < 2; w++) inv_m[w] = ie && mv[iidx][w] && mt[iidx][w] == (ia >> 3) / 64;
    inv_pend = ie && (ia >> 3) == mline;
    fw = -1;
    fidx = int'(mline % 64);
    if (rq && hit) mru[ridx] = hw;
    if (phase == 0) begin
      if (rq && !hit && !(ie && (ia >> 3) == (a >> 3))) begin
        mline = a >> 3;
        phase = 1;
      end
    end else if (phase == 1) begin
      if (inv_pend) mpois = 1;
      if (ak) phase = 2;
    end else begin
      if (dv) begin
        if (!mv[fidx][0])      fw = 0;
        else if (!mv[fidx][1]) fw = 1;
        else                   fw = 1 - mru[fidx];
        md[fidx][fw] = d;
        mt[fidx][fw] = mline / 64;
        mv[fidx][fw] = !(mpois || inv_pend);
        mru[fidx]    = fw;
        phase = 0;
        mpois = 0;
      end else if (inv_pend) begin
        mpois = 1;
      end
    end
    for (int w = 0; w < 2; w++) begin
      if (inv_m[w] && !(w == fw && fidx == iidx)) mv[iidx][w] = 0;
    end
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the expected outputs for this cycle go to the scoreboard
  task automatic step(input logic rq, input logic [63:0] a, input logic ak, input logic dv,
                      input logic [63:0] d, input logic ie, input logic [63:0] ia,
                      input logic rs);
    exp_t e;
    bit   hit;
    int   hw, idx;
    @(posedge clock);
    #2;
    reset = rs; req = rq; addr = a; ack = ak; dval = dv; mdata = d; inv = ie; inva = ia;
    if (rs) model_reset();
    lookup(a, hit, hw, idx);
    e.v  = rq && hit;
    e.d  = e.v ? md[idx][hw] : 64'h0;
    e.mr = (phase == 1);
    e.ma = (phase == 1) ? (mline << 3) : 64'h0;
    sb.push_back(e);
    if (!rs) model_advance(rq, a, ak, dv, d, ie, ia);
  endtask

  task automatic lk(input logic [63:0] a);
    step(1'b1, a, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic miss_fill(input logic [63:0] a, input logic [63:0] d);
    lk(a);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, d, 1'b0, 64'h0, 1'b0);
    lk(a);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b1, 64'hDEAD_0000_0000_BEEF, 1'b0, 64'h0, 1'b0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clock) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("proc_valid", {63'h0, pvalid}, {63'h0, e.v});
      if (e.v) chk("proc_data", pdata, e.d);
      chk("mem_req", {63'h0, mreq}, {63'h0, e.mr});
      chk("mem_addr", maddr, e.ma);
    end
  end

  initial begin
    reset = 1'b1; req = 0; ack = 0; dval = 0; inv = 0; addr = 0; mdata = 0; inva = 0;
    model_reset();
    repeat (2) step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);

    // Cold miss and fill
    miss_fill(64'h1004, 64'h0123_4567_89AB_CDEF);
    // Conflict in set 0
    miss_fill(64'h1200, 64'h1200_1200_1200_1200);
    lk(64'h1000);
    lk(64'h1000);
    miss_fill(64'h1400, 64'h1400_1400_1400_1400);
    lk(64'h1000);
    lk(64'h1200);
    drain();
    // Invalidate a resident line, then look it up
    lk(64'h1000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b0);
    lk(64'h1000);
    lk(64'h1000);
    drain();
    // Poisoned fill
    lk(64'h2000);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h2000, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h2222_2222_2222_2222, 1'b0, 64'h0, 1'b0);
    lk(64'h2000);
    lk(64'h2000);
    drain();
    // Asynchronous reset in MISS_WAIT, stale data afterwards
    lk(64'h5000);
    step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h1400, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h5555_5555_5555_5555, 1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h5555_5555_5555_5555, 1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 64'h5555_5555_5555_5555, 1'b0, 64'h0, 1'b0);
    lk(64'h5000);
    drain();
    // Hit under miss
    miss_fill(64'h1000, 64'hAAAA_BBBB_CCCC_DDDD);
    lk(64'h3000);
    lk(64'h1000);
    step(1'b1, 64'h1000, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h1000, 1'b0, 1'b1, 64'h3333_3333_3333_3333, 1'b0, 64'h0, 1'b0);
    lk(64'h3000);
    drain();

    // Randomised traffic over a small address pool to force conflicts
    for (int i = 0; i < 600; i++) begin
      logic [63:0] ra, ri;
      ra = 64'(($urandom_range(0, 2) << 9) | ($urandom_range(0, 1) << 3) | $urandom_range(0, 7));
      ri = 64'(($urandom_range(0, 2) << 9) | ($urandom_range(0, 1) << 3));
      step(logic'($urandom_range(0, 3) != 0), ra, logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) == 0), {$urandom, $urandom},
           logic'($urandom_range(0, 7) == 0), ri, 1'b0);
    end

    repeat (2) @(posedge clock);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
